stream_frame_aligner: RTL and testbench

- Registered N-channel AXI-Stream frame aligner between the OV7670 capture streams (live/new, stored reference, further channels) and the background-elimination datapath.
- Discards beats per channel until every enabled channel sits on a start-of-frame (tuser) beat, then releases all channels in lockstep through one registered output stage.
- Detects loss of alignment, resynchronises automatically and counts resync events.
- Bypass mode forwards channel 0 alone.

---
 rtl/stream_frame_aligner_if.sv | 56 +++++
 rtl/stream_frame_aligner.sv | 213 +++++++++++++++++++++
 tb/tb_stream_frame_aligner.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_frame_aligner_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_frame_aligner_if
//  Description : Stream bundle for stream_frame_aligner. It carries the
//                N-channel AXI-Stream input side (s_*) and the single common
//                aligned output side (m_*).
//                  slave  : the aligner's view (sinks s_*, sources m_*)
//                  master : the environment's view (sources s_*, sinks m_*)
//  Ports       : (interface signals)
//                  s_tdata  [N_CH*DATA_W] channel k at [k*DATA_W +: DATA_W]
//                  s_tuser  [N_CH]        start-of-frame per channel
//                  s_tvalid [N_CH]        per-channel valid
//                  s_tready [N_CH]        per-channel ready
//                  m_tdata  [N_CH*DATA_W] aligned output data
//                  m_tuser                output start-of-frame
//                  m_tvalid               common output valid
//                  m_tready               downstream ready, all lanes
//  Revision    : 1.0 - initial release
// ============================================================================
interface stream_frame_aligner_if #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 2
);
    logic [N_CH*DATA_W-1:0] s_tdata;
    logic [N_CH-1:0]        s_tuser;
    logic [N_CH-1:0]        s_tvalid;
    logic [N_CH-1:0]        s_tready;

    logic [N_CH*DATA_W-1:0] m_tdata;
    logic                   m_tuser;
    logic                   m_tvalid;
    logic                   m_tready;

    modport slave (
        input  s_tdata,
        input  s_tuser,
        input  s_tvalid,
        output s_tready,
        output m_tdata,
        output m_tuser,
        output m_tvalid,
        input  m_tready
    );

    modport master (
        output s_tdata,
        output s_tuser,
        output s_tvalid,
        input  s_tready,
        input  m_tdata,
        input  m_tuser,
        input  m_tvalid,
        output m_tready
    );
endinterface
`default_nettype wire

// File: rtl/stream_frame_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : stream_frame_aligner
//  Description : Registered N-channel AXI-Stream frame aligner. Drops beats
//                on each channel until every channel sits on a start-of-frame
//                beat, then releases all channels in lockstep through one
//                registered output stage. Loss of alignment (mixed tuser on a
//                common beat) forces an automatic resync, and each resync is
//                counted. With enable low only channel 0 is forwarded.
//  Ports       : aclk        clock, rising edge
//                aresetn     asynchronous active-low reset
//                enable      1 = align mode, 0 = bypass mode
//                bus         stream bundle (slave modport)
//                aligned     high while in the ALIGNED state (registered)
//                resync_cnt  saturating count of ALIGNED->SEARCH transitions
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_frame_aligner #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 2,
    parameter int CNT_W  = 16
) (
    input  wire logic               aclk,
    input  wire logic               aresetn,
    input  wire logic               enable,
    stream_frame_aligner_if.slave   bus,
    output logic                    aligned,
    output logic [CNT_W-1:0]        resync_cnt
);

    typedef enum logic [1:0] {
        ST_BYPASS  = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_ALIGNED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic                   r_run;      // 0 only in the first cycle after reset
    logic [N_CH-1:0]        r_hold;     // per-channel "SOF parked at input"
    logic [N_CH*DATA_W-1:0] r_tdata;
    logic                   r_tuser;
    logic                   r_tvalid;
    logic                   r_aligned;
    logic [CNT_W-1:0]       r_cnt;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t                 w_state;
    state_t                 w_state_nxt;
    logic [N_CH-1:0]        w_hold_nxt;
    logic [N_CH*DATA_W-1:0] w_tdata_nxt;
    logic                   w_tuser_nxt;
    logic                   w_tvalid_nxt;
    logic                   w_cnt_inc;
    logic [N_CH-1:0]        w_ready;
    logic                   w_ld;
    logic                   w_all_valid;
    logic                   w_misalign;
    logic                   w_fire;

    // The reset value of the state depends on enable. Rather than loading a
    // non-constant value under asynchronous reset, the state register resets
    // to a fixed value and r_run marks the first post-reset cycle, during
    // which the effective state is taken directly from enable.
    always_comb begin
        w_state = r_state;
        if (!r_run) begin
            w_state = enable ? ST_SEARCH : ST_BYPASS;
        end
    end

    // Output register may take a new beat when empty or being drained.
    assign w_ld        = !r_tvalid || bus.m_tready;
    assign w_all_valid = &bus.s_tvalid;
    // A common beat with some, but not all, channels flagging SOF.
    assign w_misalign  = w_all_valid && (|bus.s_tuser) && !(&bus.s_tuser);
    // All-or-none consumption; a misaligned beat is never consumed.
    assign w_fire      = (w_state == ST_ALIGNED) && w_all_valid && !w_misalign && w_ld;

    // ------------------------------------------------------------------
    // Next-state, ready and output-stage logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = w_state;
        w_hold_nxt   = r_hold;
        w_tdata_nxt  = r_tdata;
        w_tuser_nxt  = r_tuser;
        w_tvalid_nxt = r_tvalid;
        w_cnt_inc    = 1'b0;
        w_ready      = '0;

        case (w_state)
            ST_BYPASS: begin
                w_ready[0] = w_ld;
                if (w_ld) begin
                    if (bus.s_tvalid[0]) begin
                        w_tdata_nxt             = '0;
                        w_tdata_nxt[DATA_W-1:0] = bus.s_tdata[DATA_W-1:0];
                        w_tuser_nxt             = bus.s_tuser[0];
                        w_tvalid_nxt            = 1'b1;
                    end else begin
                        w_tvalid_nxt = 1'b0;
                    end
                end
                if (enable) begin
                    w_state_nxt = ST_SEARCH;
                end
            end

            ST_SEARCH: begin
                // Non-held channels drain junk but never swallow an SOF beat;
                // held channels keep their SOF beat parked at the input.
                w_ready    = ~r_hold & ~bus.s_tuser;
                w_hold_nxt = r_hold | (bus.s_tvalid & bus.s_tuser);
                if (w_ld) begin
                    w_tvalid_nxt = 1'b0;
                end
                if (&r_hold) begin
                    w_state_nxt = ST_ALIGNED;
                    w_hold_nxt  = '0;
                end
                // Leaving align mode has priority over completing the search.
                if (!enable) begin
                    w_state_nxt = ST_BYPASS;
                    w_hold_nxt  = '0;
                end
            end

            ST_ALIGNED: begin
                w_ready = {N_CH{w_fire}};
                if (w_fire) begin
                    w_tdata_nxt  = bus.s_tdata;
                    w_tuser_nxt  = bus.s_tuser[0];
                    w_tvalid_nxt = 1'b1;
                end else if (w_ld) begin
                    w_tvalid_nxt = 1'b0;
                end
                if (w_misalign) begin
                    // Channels already on SOF stay parked as candidates.
                    w_state_nxt = ST_SEARCH;
                    w_hold_nxt  = bus.s_tuser & bus.s_tvalid;
                    w_cnt_inc   = 1'b1;
                end
                // Dropping enable is a mode change, not a resync event.
                if (!enable) begin
                    w_state_nxt = ST_BYPASS;
                    w_hold_nxt  = '0;
                    w_cnt_inc   = 1'b0;
                end
            end

            default: begin
                w_state_nxt = enable ? ST_SEARCH : ST_BYPASS;
                w_hold_nxt  = '0;
                if (w_ld) begin
                    w_tvalid_nxt = 1'b0;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_SEARCH;
            r_run   <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            r_hold  <= w_hold_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output stage, status and resync counter
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tdata   <= '0;
            r_tuser   <= 1'b0;
            r_tvalid  <= 1'b0;
            r_aligned <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_tdata   <= w_tdata_nxt;
            r_tuser   <= w_tuser_nxt;
            r_tvalid  <= w_tvalid_nxt;
            r_aligned <= (w_state_nxt == ST_ALIGNED);
            if (w_cnt_inc && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Nothing is accepted while reset is asserted.
    assign bus.s_tready = aresetn ? w_ready : '0;
    assign bus.m_tdata  = r_tdata;
    assign bus.m_tuser  = r_tuser;
    assign bus.m_tvalid = r_tvalid;
    assign aligned      = r_aligned;
    assign resync_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_frame_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_frame_aligner
//  Description : Directed self-checking bench for stream_frame_aligner
//                (DATA_W=8, N_CH=2, CNT_W=2 so counter saturation is reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_frame_aligner;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       enable;
    logic       aligned;
    logic [1:0] resync_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    stream_frame_aligner_if #(.DATA_W(8), .N_CH(2)) ifc ();

    stream_frame_aligner #(
        .DATA_W (8),
        .N_CH   (2),
        .CNT_W  (2)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .enable     (enable),
        .bus        (ifc.slave),
        .aligned    (aligned),
        .resync_cnt (resync_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] u,
                         input logic [7:0] d1, input logic [7:0] d0);
        ifc.s_tvalid = v;
        ifc.s_tuser  = u;
        ifc.s_tdata  = {d1, d0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         in_idx;
        int         out_n;
        logic       in_hs;
        logic       stall;
        logic [15:0] sdata;
        logic [7:0] b;
        logic [15:0] exp_d;

        // ---------------- reset ----------------
        aresetn       = 1'b0;
        enable        = 1'b1;
        ifc.m_tready  = 1'b1;
        drive(2'b11, 2'b01, 8'h00, 8'hA0);
        tick(); tick();
        chk("rst_tvalid", ifc.m_tvalid, 0);
        chk("rst_tdata", ifc.m_tdata, 0);
        chk("rst_tuser", ifc.m_tuser, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_cnt", resync_cnt, 0);
        chk("rst_tready", ifc.s_tready, 2'b00);
        aresetn = 1'b1;

        // ---------------- initial search: ch1 5 junk beats then SOF ----------------
        for (int j = 0; j < 5; j++) begin
            drive(2'b11, 2'b01, 8'(j + 1), 8'hA0);
            #1;
            chk("search_tready", ifc.s_tready, 2'b10);
            chk("search_aligned", aligned, 0);
            tick();
        end
        drive(2'b11, 2'b11, 8'hB0, 8'hA0);
        #1;
        chk("sof_parked_tready", ifc.s_tready, 2'b00);
        tick();
        chk("aligned_after_1", aligned, 0);
        tick();
        chk("aligned_after_2", aligned, 1);
        chk("no_out_in_search", ifc.m_tvalid, 0);
        chk("aligned_tready", ifc.s_tready, 2'b11);
        tick();
        chk("first_tvalid", ifc.m_tvalid, 1);
        chk("first_tuser", ifc.m_tuser, 1);
        chk("first_tdata", ifc.m_tdata, 16'hB0A0);

        // ---------------- 16-beat frame with m_tready toggling ----------------
        in_idx = 1;
        out_n  = 0;
        for (int cyc = 0; cyc < 200 && out_n < 16; cyc++) begin
            ifc.m_tready = (cyc % 2 == 0);
            if (in_idx <= 15) begin
                b = 8'(in_idx);
                drive(2'b11, 2'b00, b, b);
            end else begin
                drive(2'b00, 2'b00, 8'h00, 8'h00);
            end
            #1;
            in_hs = (ifc.s_tready == 2'b11) && (ifc.s_tvalid == 2'b11);
            if (ifc.m_tvalid && ifc.m_tready) begin
                b     = 8'(out_n);
                exp_d = (out_n == 0) ? 16'hB0A0 : {b, b};
                chk("frame_tdata", ifc.m_tdata, exp_d);
                chk("frame_tuser", ifc.m_tuser, (out_n == 0) ? 1 : 0);
                out_n++;
            end
            stall = ifc.m_tvalid && !ifc.m_tready;
            sdata = ifc.m_tdata;
            tick();
            if (in_hs) in_idx++;
            if (stall) begin
                chk("stall_tvalid", ifc.m_tvalid, 1);
                chk("stall_tdata", ifc.m_tdata, sdata);
            end
        end
        chk("frame_beats", out_n, 16);
        chk("frame_inputs", in_idx, 16);
        ifc.m_tready = 1'b1;

        // ---------------- misalignment faults, counter saturates at 3 ----------------
        for (int f = 1; f <= 4; f++) begin
            drive(2'b11, 2'b01, 8'h66, 8'h55);
            #1;
            chk("misalign_tready", ifc.s_tready, 2'b00);
            tick();
            chk("misalign_aligned", aligned, 0);
            chk("misalign_cnt", resync_cnt, (f > 3) ? 3 : f);
            drive(2'b11, 2'b11, 8'h77, 8'h55);
            tick(); tick();
            chk("realign_aligned", aligned, 1);
            tick();
            chk("realign_tvalid", ifc.m_tvalid, 1);
            chk("realign_tdata", ifc.m_tdata, 16'h7755);
            chk("realign_tuser", ifc.m_tuser, 1);
            drive(2'b00, 2'b00, 8'h00, 8'h00);
            tick();
        end

        // ---------------- bypass: ch0 0x10..0x17 ----------------
        enable = 1'b0;
        tick();
        chk("bypass_aligned", aligned, 0);
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, {1'b0, (i == 0)}, 8'hEE, 8'(8'h10 + i));
            #1;
            chk("bypass_tready", ifc.s_tready, 2'b01);
            tick();
            chk("bypass_tvalid", ifc.m_tvalid, 1);
            chk("bypass_tdata", ifc.m_tdata, {8'h00, 8'(8'h10 + i)});
            chk("bypass_tuser", ifc.m_tuser, (i == 0) ? 1 : 0);
        end
        drive(2'b00, 2'b00, 8'h00, 8'h00);
        tick();
        chk("bypass_idle", ifc.m_tvalid, 0);

        // ---------------- enable 1->0 with a stalled output beat ----------------
        enable = 1'b1;
        tick();
        chk("reenable_aligned", aligned, 0);
        drive(2'b11, 2'b11, 8'hD0, 8'hC0);
        tick(); tick();
        chk("sw_aligned", aligned, 1);
        ifc.m_tready = 1'b0;
        tick();
        chk("sw_tvalid", ifc.m_tvalid, 1);
        chk("sw_tdata", ifc.m_tdata, 16'hD0C0);
        drive(2'b00, 2'b00, 8'h00, 8'h00);
        enable = 1'b0;
        tick();
        chk("sw_held_tvalid", ifc.m_tvalid, 1);
        chk("sw_held_tdata", ifc.m_tdata, 16'hD0C0);
        chk("sw_aligned_drop", aligned, 0);
        drive(2'b01, 2'b00, 8'h00, 8'h21);
        #1;
        chk("sw_stall_tready", ifc.s_tready, 2'b00);
        tick();
        chk("sw_still_held", ifc.m_tdata, 16'hD0C0);
        ifc.m_tready = 1'b1;
        #1;
        chk("sw_drain_tready", ifc.s_tready, 2'b01);
        tick();
        chk("sw_bypass_tdata", ifc.m_tdata, 16'h0021);
        chk("sw_bypass_tvalid", ifc.m_tvalid, 1);
        drive(2'b00, 2'b00, 8'h00, 8'h00);
        tick();
        chk("sw_bypass_idle", ifc.m_tvalid, 0);
        enable = 1'b1;
        tick();
        drive(2'b11, 2'b01, 8'h99, 8'hE0);
        #1;
        chk("sw_search_tready", ifc.s_tready, 2'b10);
        tick();
        chk("sw_search_aligned", aligned, 0);
        chk("sw_cnt_kept", resync_cnt, 3);

        // ---------------- async reset with output stalled ----------------
        drive(2'b11, 2'b11, 8'hF0, 8'hE0);
        tick(); tick();
        chk("pre_rst_aligned", aligned, 1);
        ifc.m_tready = 1'b0;
        tick();
        chk("pre_rst_tvalid", ifc.m_tvalid, 1);
        chk("pre_rst_tdata", ifc.m_tdata, 16'hF0E0);
        drive(2'b11, 2'b00, 8'h01, 8'h01);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_tvalid", ifc.m_tvalid, 0);
        chk("arst_tdata", ifc.m_tdata, 0);
        chk("arst_aligned", aligned, 0);
        chk("arst_cnt", resync_cnt, 0);
        chk("arst_tready", ifc.s_tready, 2'b00);
        tick(); tick();
        aresetn      = 1'b1;
        ifc.m_tready = 1'b1;
        drive(2'b11, 2'b01, 8'h4B, 8'h3A);
        #1;
        chk("post_rst_tready", ifc.s_tready, 2'b10);
        tick();
        chk("post_rst_aligned", aligned, 0);
        drive(2'b11, 2'b11, 8'h4C, 8'h3A);
        tick(); tick();
        chk("post_rst_realigned", aligned, 1);
        tick();
        chk("post_rst_tvalid", ifc.m_tvalid, 1);
        chk("post_rst_tdata", ifc.m_tdata, 16'h4C3A);
        chk("post_rst_tuser", ifc.m_tuser, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
